// File: rtl/aes_key_sched_pkg.sv
// rtl/aes_key_sched_pkg.sv - mode encodings, per-mode constants, xtime and FSM states for the AES key scheduler
package aes_key_sched_pkg;

  localparam int N_WORDS_MAX = 60;
  localparam int IDX_W       = 6;

  typedef enum logic [1:0] {
    KEY_SIZE_128     = 2'd0,
    KEY_SIZE_192     = 2'd1,
    KEY_SIZE_256     = 2'd2,
    KEY_SIZE_ILLEGAL = 2'd3
  } key_size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Key length in 32-bit words.
  function automatic logic [3:0] get_nk(input key_size_e mode);
    case (mode)
      KEY_SIZE_128: return 4'd4;
      KEY_SIZE_192: return 4'd6;
      default:      return 4'd8;
    endcase
  endfunction

  // Total number of expanded words, 4*(Nr+1).
  function automatic logic [IDX_W-1:0] get_nw(input key_size_e mode);
    case (mode)
      KEY_SIZE_128: return 6'd44;
      KEY_SIZE_192: return 6'd52;
      default:      return 6'd60;
    endcase
  endfunction

  // Number of cipher rounds.
  function automatic logic [3:0] get_nr(input key_size_e mode);
    case (mode)
      KEY_SIZE_128: return 4'd10;
      KEY_SIZE_192: return 4'd12;
      default:      return 4'd14;
    endcase
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/key_sched_word_unit.sv
// rtl/key_sched_word_unit.sv - combinational next-word computation for the AES key schedule
module key_sched_word_unit (
  input  logic [31:0] i_w_prev,
  input  logic [31:0] i_w_nk,
  input  logic [2:0]  i_word_mod,
  input  logic        i_is_256,
  input  logic [7:0]  i_rcon,
  output logic [31:0] o_word
);

  logic        rot_sel;
  logic [31:0] sbox_in;
  logic [31:0] sbox_out;
  logic [31:0] t_word;

  assign rot_sel = (i_word_mod == 3'd0);
  assign sbox_in = rot_sel ? {i_w_prev[23:0], i_w_prev[31:24]} : i_w_prev;

  subbytes_block #(
    .N_BYTES           (4),
    .CREATE_OUTPUT_REG (0)
  ) u_sbox (
    .i_clock (1'b0),
    .i_state (sbox_in),
    .o_state (sbox_out)
  );

  // Select the mixing term: rotated+substituted+rcon, substituted only (AES-256 mid-key), or plain.
  always_comb begin
    t_word = i_w_prev;
    if (rot_sel) begin
      t_word = sbox_out ^ {i_rcon, 24'h000000};
    end else if (i_is_256 && (i_word_mod == 3'd4)) begin
      t_word = sbox_out;
    end
  end

  assign o_word = i_w_nk ^ t_word;

endmodule

// File: rtl/subbytes_block.sv
// rtl/subbytes_block.sv - AES forward S-box over N_BYTES bytes, optional output register
module subbytes_block #(
  parameter int N_BYTES           = 4,
  parameter int CREATE_OUTPUT_REG = 0
) (
  input  logic                 i_clock,
  input  logic [N_BYTES*8-1:0] i_state,
  output logic [N_BYTES*8-1:0] o_state
);

  // Entry x lives at bits [(255-x)*8 +: 8], i.e. entry 0 in the MSBs.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [N_BYTES*8-1:0] sub_bytes;

  // Per-byte table lookup; ~x*8 is the offset of entry x from the LSB end.
  always_comb begin
    sub_bytes = '0;
    for (int b = 0; b < N_BYTES; b++) begin
      sub_bytes[b*8 +: 8] = SBOX_TABLE[{~i_state[b*8 +: 8], 3'b000} +: 8];
    end
  end

  if (CREATE_OUTPUT_REG != 0) begin : g_out_reg
    // Registered output for pipelined users.
    always_ff @(posedge i_clock) begin
      o_state <= sub_bytes;
    end
  end else begin : g_out_comb
    logic unused_clock;
    assign unused_clock = i_clock;
    assign o_state      = sub_bytes;
  end

endmodule

// File: rtl/key_scheduler_seq.sv
// rtl/key_scheduler_seq.sv - iterative AES-128/192/256 key expansion; KEY_SCHED_ZEROIZE_EN adds i_zeroize
module key_scheduler_seq
  import aes_key_sched_pkg::*;
#(
  parameter int NB_BYTE         = 8,
  parameter int N_BYTES_STATE   = 16,
  parameter int N_BYTES_KEY_MAX = 32,
  parameter int N_ROUNDS_MAX    = 14
) (
  input  logic                                             i_clock,
  input  logic                                             i_reset,
`ifdef KEY_SCHED_ZEROIZE_EN
  input  logic                                             i_zeroize,
`endif
  input  logic                                             i_start,
  input  logic [1:0]                                       i_key_size,
  input  logic [N_BYTES_KEY_MAX*NB_BYTE-1:0]               i_key,
  output logic [N_BYTES_STATE*NB_BYTE*(N_ROUNDS_MAX+1)-1:0] o_round_key_vector,
  output logic                                             o_busy,
  output logic                                             o_done,
  output logic                                             o_keys_valid,
  output logic                                             o_cfg_err
);

  localparam int WORD_W    = 4 * NB_BYTE;
  localparam int STATE_W   = N_BYTES_STATE * NB_BYTE;
  localparam int WPS       = N_BYTES_STATE / 4;
  localparam int N_WORDS   = WPS * (N_ROUNDS_MAX + 1);
  localparam int KEY_W     = N_BYTES_KEY_MAX * NB_BYTE;
  localparam int KEY_WORDS = N_BYTES_KEY_MAX / 4;

  if (NB_BYTE != 8 || N_WORDS != N_WORDS_MAX) begin : g_bad_cfg
    $error("key_scheduler_seq: unsupported configuration");
  end

  state_e                 state_q, state_d;
  key_size_e              mode_q;
  logic [KEY_W-1:0]       key_q;
  logic [WORD_W-1:0]      w_q [N_WORDS];
  logic [IDX_W-1:0]       i_q;
  logic [2:0]             mod_q;
  logic [7:0]             rcon_q;
  logic                   done_q, valid_q, cfg_err_q;
  logic                   accept, load_en, expand_en, finish, cfg_err_d;
  logic                   zeroize;
  logic [3:0]             nk;
  logic [IDX_W-1:0]       nw;
  logic [WORD_W-1:0]      w_prev, w_nk, w_new;

`ifdef KEY_SCHED_ZEROIZE_EN
  assign zeroize = i_zeroize;
`else
  assign zeroize = 1'b0;
`endif

  assign nk     = get_nk(mode_q);
  assign nw     = get_nw(mode_q);
  assign w_prev = w_q[i_q - 6'd1];
  assign w_nk   = w_q[i_q - {2'b00, nk}];

  key_sched_word_unit u_word_unit (
    .i_w_prev   (w_prev),
    .i_w_nk     (w_nk),
    .i_word_mod (mod_q),
    .i_is_256   (mode_q == KEY_SIZE_256),
    .i_rcon     (rcon_q),
    .o_word     (w_new)
  );

  // FSM state register.
  always_ff @(posedge i_clock) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state and datapath strobes; zeroize overrides everything.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    cfg_err_d = 1'b0;
    load_en   = 1'b0;
    expand_en = 1'b0;
    finish    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          if (i_key_size == KEY_SIZE_ILLEGAL) begin
            cfg_err_d = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        load_en = 1'b1;
        state_d = ST_EXPAND;
      end
      ST_EXPAND: begin
        if (i_q == nw) begin
          finish  = 1'b1;
          state_d = ST_DONE;
        end else begin
          expand_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (zeroize) begin
      state_d   = ST_IDLE;
      accept    = 1'b0;
      cfg_err_d = 1'b0;
      load_en   = 1'b0;
      expand_en = 1'b0;
      finish    = 1'b0;
    end
  end

  // Key storage, word counter, rcon and status flags.
  always_ff @(posedge i_clock) begin
    if (i_reset || zeroize) begin
      for (int k = 0; k < N_WORDS; k++) w_q[k] <= '0;
      key_q     <= '0;
      mode_q    <= KEY_SIZE_128;
      i_q       <= '0;
      mod_q     <= '0;
      rcon_q    <= i_reset ? 8'h01 : 8'h00;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      done_q    <= finish;
      cfg_err_q <= cfg_err_d;
      if (accept) begin
        key_q   <= i_key;
        mode_q  <= key_size_e'(i_key_size);
        valid_q <= 1'b0;
        for (int k = 0; k < N_WORDS; k++) w_q[k] <= '0;
      end
      if (load_en) begin
        for (int k = 0; k < KEY_WORDS; k++) begin
          if (k < int'(nk)) w_q[k] <= key_q[KEY_W-1-WORD_W*k -: WORD_W];
        end
        i_q    <= {2'b00, nk};
        mod_q  <= '0;
        rcon_q <= 8'h01;
      end
      if (expand_en) begin
        w_q[i_q] <= w_new;
        i_q      <= i_q + 6'd1;
        mod_q    <= ({1'b0, mod_q} == nk - 4'd1) ? 3'd0 : mod_q + 3'd1;
        if (mod_q == 3'd0) rcon_q <= xtime(rcon_q);
      end
      if (finish) valid_q <= 1'b1;
    end
  end

  for (genvar j = 0; j < N_WORDS; j++) begin : g_out_map
    assign o_round_key_vector[(j/WPS)*STATE_W + (WPS-1-(j%WPS))*WORD_W +: WORD_W] = w_q[j];
  end

  assign o_busy       = (state_q == ST_LOAD) || (state_q == ST_EXPAND);
  assign o_done       = done_q;
  assign o_keys_valid = valid_q;
  assign o_cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_key_scheduler_seq.sv
// tb/tb_key_scheduler_seq.sv - directed self-checking bench for key_scheduler_seq
module tb_key_scheduler_seq;

  logic          i_clock;
  logic          i_reset;
  logic          i_zeroize;
  logic          i_start;
  logic [1:0]    i_key_size;
  logic [255:0]  i_key;
  logic [1919:0] o_round_key_vector;
  logic          o_busy, o_done, o_keys_valid, o_cfg_err;

  int checks = 0;
  int passed = 0;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef_cafef00d_12345678_9abcdef0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hffffffff_ffffffff};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  key_scheduler_seq dut (
    .i_clock            (i_clock),
    .i_reset            (i_reset),
`ifdef KEY_SCHED_ZEROIZE_EN
    .i_zeroize          (i_zeroize),
`endif
    .i_start            (i_start),
    .i_key_size         (i_key_size),
    .i_key              (i_key),
    .o_round_key_vector (o_round_key_vector),
    .o_busy             (o_busy),
    .o_done             (o_done),
    .o_keys_valid       (o_keys_valid),
    .o_cfg_err          (o_cfg_err)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  function automatic logic [31:0] kw(input int j);
    logic [1919:0] v;
    v = o_round_key_vector;
    return v[(j/4)*128 + (3 - j%4)*32 +: 32];
  endfunction

  task automatic start_and_wait(input logic [1:0] size, input logic [255:0] key,
                                output int lat, output logic busy0, output logic valid0, output logic done0);
    i_key = key; i_key_size = size; i_start = 1'b1;
    @(posedge i_clock); #1;
    i_start = 1'b0;
    busy0 = o_busy; valid0 = o_keys_valid; done0 = o_done;
    lat = 0;
    while (o_done !== 1'b1 && lat < 200) begin
      @(posedge i_clock); #1; lat++;
    end
    if (o_done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (2) @(posedge i_clock);
    #1;
    checks++; if (o_round_key_vector !== '0) $display("FAIL reset_vector: got nonzero expected 0"); else passed++;
    checks++; if ({o_busy, o_done, o_keys_valid, o_cfg_err} !== 4'b0000) $display("FAIL reset_flags: got %b expected 0000", {o_busy, o_done, o_keys_valid, o_cfg_err}); else passed++;
    i_reset = 1'b0;
  endtask

  task automatic test_aes128();
    int lat; logic b0, v0, d0;
    start_and_wait(2'd0, K128, lat, b0, v0, d0);
    checks++; if (b0 !== 1'b1) $display("FAIL aes128_busy_after_start: got %b expected 1", b0); else passed++;
    checks++; if (lat !== 42) $display("FAIL aes128_latency: got %0d expected 42", lat); else passed++;
    checks++; if (kw(0) !== 32'h2b7e1516) $display("FAIL aes128_w0: got %h expected 2b7e1516", kw(0)); else passed++;
    checks++; if ({kw(4), kw(5)} !== 64'ha0fafe17_88542cb1) $display("FAIL aes128_w4_w5: got %h expected a0fafe1788542cb1", {kw(4), kw(5)}); else passed++;
    checks++; if ({kw(40), kw(41), kw(42), kw(43)} !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) $display("FAIL aes128_round10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", {kw(40), kw(41), kw(42), kw(43)}); else passed++;
    for (int r = 11; r <= 14; r++) begin
      checks++; if (o_round_key_vector[r*128 +: 128] !== '0) $display("FAIL aes128_slot%0d_zero: got %h expected 0", r, o_round_key_vector[r*128 +: 128]); else passed++;
    end
    checks++; if ({o_keys_valid, o_busy} !== 2'b10) $display("FAIL aes128_valid_busy: got %b expected 10", {o_keys_valid, o_busy}); else passed++;
  endtask

  task automatic test_aes192_back_to_back();
    int lat; logic b0, v0, d0;
    checks++; if (o_done !== 1'b1) $display("FAIL b2b_done_before_start: got %b expected 1", o_done); else passed++;
    start_and_wait(2'd1, K192, lat, b0, v0, d0);
    checks++; if ({b0, v0, d0} !== 3'b100) $display("FAIL b2b_after_start busy/valid/done: got %b expected 100", {b0, v0, d0}); else passed++;
    checks++; if (lat !== 48) $display("FAIL aes192_latency: got %0d expected 48", lat); else passed++;
    checks++; if (kw(6) !== 32'hfe0c91f7) $display("FAIL aes192_w6: got %h expected fe0c91f7", kw(6)); else passed++;
    checks++; if ({kw(48), kw(49), kw(50), kw(51)} !== 128'he98ba06f448c773c8ecc720401002202) $display("FAIL aes192_round12: got %h expected e98ba06f448c773c8ecc720401002202", {kw(48), kw(49), kw(50), kw(51)}); else passed++;
    checks++; if (o_round_key_vector[13*128 +: 256] !== '0) $display("FAIL aes192_slots13_14_zero: got nonzero expected 0"); else passed++;
  endtask

  task automatic test_aes256();
    int lat; logic b0, v0, d0;
    start_and_wait(2'd2, K256, lat, b0, v0, d0);
    checks++; if (lat !== 54) $display("FAIL aes256_latency: got %0d expected 54", lat); else passed++;
    checks++; if (kw(8) !== 32'h9ba35411) $display("FAIL aes256_w8: got %h expected 9ba35411", kw(8)); else passed++;
    checks++; if ({kw(56), kw(57), kw(58), kw(59)} !== 128'hfe4890d1e6188d0b046df344706c631e) $display("FAIL aes256_round14: got %h expected fe4890d1e6188d0b046df344706c631e", {kw(56), kw(57), kw(58), kw(59)}); else passed++;
  endtask

  task automatic test_cfg_err();
    i_key = K128; i_key_size = 2'd3; i_start = 1'b1;
    @(posedge i_clock); #1;
    i_start = 1'b0;
    checks++; if ({o_cfg_err, o_busy, o_keys_valid} !== 3'b101) $display("FAIL cfg_err_pulse err/busy/valid: got %b expected 101", {o_cfg_err, o_busy, o_keys_valid}); else passed++;
    @(posedge i_clock); #1;
    checks++; if ({o_cfg_err, o_busy} !== 2'b00) $display("FAIL cfg_err_single_cycle: got %b expected 00", {o_cfg_err, o_busy}); else passed++;
    checks++; if (kw(59) !== 32'h706c631e) $display("FAIL cfg_err_keys_kept: got %h expected 706c631e", kw(59)); else passed++;
  endtask

  task automatic test_restart_ignored();
    int n;
    i_key = K128; i_key_size = 2'd0; i_start = 1'b1;
    @(posedge i_clock); #1;
    i_start = 1'b0; n = 0;
    repeat (5) begin @(posedge i_clock); #1; n++; end
    i_key = K256; i_key_size = 2'd2; i_start = 1'b1;
    @(posedge i_clock); #1;
    i_start = 1'b0; n++;
    checks++; if (o_busy !== 1'b1) $display("FAIL restart_still_busy: got %b expected 1", o_busy); else passed++;
    i_key_size = 2'd3; i_start = 1'b1;
    @(posedge i_clock); #1;
    i_start = 1'b0; n++;
    checks++; if (o_cfg_err !== 1'b0) $display("FAIL busy_illegal_no_err: got %b expected 0", o_cfg_err); else passed++;
    while (o_done !== 1'b1 && n < 200) begin @(posedge i_clock); #1; n++; end
    checks++; if (n !== 42) $display("FAIL restart_latency: got %0d expected 42", n); else passed++;
    checks++; if ({kw(4), kw(43)} !== 64'ha0fafe17_b6630ca6) $display("FAIL restart_keys: got %h expected a0fafe17b6630ca6", {kw(4), kw(43)}); else passed++;
    checks++; if (o_round_key_vector[11*128 +: 128] !== '0) $display("FAIL restart_slot11_zero: got nonzero expected 0"); else passed++;
  endtask

  task automatic test_reset_mid();
    int lat; logic b0, v0, d0;
    i_key = K256; i_key_size = 2'd2; i_start = 1'b1;
    @(posedge i_clock); #1;
    i_start = 1'b0;
    repeat (10) @(posedge i_clock);
    #1;
    i_reset = 1'b1;
    @(posedge i_clock); #1;
    i_reset = 1'b0;
    checks++; if (o_round_key_vector !== '0) $display("FAIL midreset_vector: got nonzero expected 0"); else passed++;
    checks++; if ({o_busy, o_done, o_keys_valid, o_cfg_err} !== 4'b0000) $display("FAIL midreset_flags: got %b expected 0000", {o_busy, o_done, o_keys_valid, o_cfg_err}); else passed++;
    start_and_wait(2'd1, K192, lat, b0, v0, d0);
    checks++; if (lat !== 48) $display("FAIL midreset_fresh_latency: got %0d expected 48", lat); else passed++;
    checks++; if (kw(51) !== 32'h01002202) $display("FAIL midreset_fresh_w51: got %h expected 01002202", kw(51)); else passed++;
  endtask

`ifdef KEY_SCHED_ZEROIZE_EN
  task automatic test_zeroize();
    int lat; logic b0, v0, d0;
    i_zeroize = 1'b1; i_key = K128; i_key_size = 2'd0; i_start = 1'b1;
    @(posedge i_clock); #1;
    i_zeroize = 1'b0; i_start = 1'b0;
    checks++; if (o_round_key_vector !== '0) $display("FAIL zeroize_vector: got nonzero expected 0"); else passed++;
    checks++; if ({o_busy, o_done, o_keys_valid, o_cfg_err} !== 4'b0000) $display("FAIL zeroize_flags: got %b expected 0000", {o_busy, o_done, o_keys_valid, o_cfg_err}); else passed++;
    start_and_wait(2'd2, K256, lat, b0, v0, d0);
    checks++; if (lat !== 54) $display("FAIL zeroize_fresh_latency: got %0d expected 54", lat); else passed++;
    checks++; if (kw(59) !== 32'h706c631e) $display("FAIL zeroize_fresh_w59: got %h expected 706c631e", kw(59)); else passed++;
  endtask
`endif

  initial begin
    i_reset = 1'b1; i_zeroize = 1'b0; i_start = 1'b0; i_key_size = 2'd0; i_key = '0;
    test_reset();
    test_aes128();
    test_aes192_back_to_back();
    test_aes256();
    test_cfg_err();
    test_restart_ignored();
    test_reset_mid();
`ifdef KEY_SCHED_ZEROIZE_EN
    test_zeroize();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/key_scheduler_seq.md
Name: key_scheduler_seq

Overview:
Iterative AES key expansion engine for AES-128, AES-192 and AES-256, selected at run time.
- Produces one 32-bit key word per clock from a single shared 4-byte S-box path.
- Stores all round keys in an internal register bank and presents them as a flat vector to the cipher datapath.
- Trades the fully unrolled combinational scheduler's area for latency; used where keys change rarely.

Parameters:
NB_BYTE, 8, bits per byte; any other value is a bad configuration.
N_BYTES_STATE, 16, bytes per round key.
N_BYTES_KEY_MAX, 32, widest supported key in bytes; sets the i_key width.
N_ROUNDS_MAX, 14, rounds for the widest key; sets the output width.

Ports:
i_clock  in  1  single clock for the block; all logic on its rising edge.
i_reset  in  1  synchronous, active-high reset.
i_start  in  1  one-cycle request to expand i_key; honoured only in IDLE or DONE.
i_key_size  in  2  mode: 0 = AES-128, 1 = AES-192, 2 = AES-256, 3 = illegal.
i_key  in  N_BYTES_KEY_MAX*NB_BYTE  key, left-aligned (MSB first); unused LSBs ignored.
o_round_key_vector  out  N_BYTES_STATE*NB_BYTE*(N_ROUNDS_MAX+1)  round key r at [r*128 +: 128]; word 4r in the MSBs.
o_busy  out  1  high in LOAD and EXPAND.
o_done  out  1  one-cycle pulse when expansion completes.
o_keys_valid  out  1  level; high from o_done until the next accepted start or reset.
o_cfg_err  out  1  one-cycle pulse when i_start is sampled with i_key_size = 3.

Behaviour:
- Reset values: all outputs 0, storage 0, FSM in IDLE, rcon register = 8'h01.
- Constants per mode: Nk = 4 / 6 / 8; total words Nw = 44 / 52 / 60; Nr = 10 / 12 / 14.
- FSM states: IDLE, LOAD, EXPAND, DONE.
- IDLE/DONE with i_start and legal mode:
  - Latch key and mode; clear o_keys_valid; go to LOAD.
- IDLE/DONE with i_start and mode 3:
  - Pulse o_cfg_err; state and stored keys unchanged.
- LOAD (1 cycle):
  - Write words 0..Nk-1 from i_key.
  - Word counter i = Nk; rcon = 8'h01; go to EXPAND.
- EXPAND: each cycle computes w[i] = w[i-Nk] ^ t, where t depends on i mod Nk:
  - i mod Nk = 0: t = SubWord(RotWord(w[i-1])) ^ {rcon, 24'h0}; then rcon = xtime(rcon).
  - Nk = 8 and i mod 8 = 4: t = SubWord(w[i-1]).
  - Otherwise: t = w[i-1].
  - xtime is a left shift with conditional reduction by 8'h1b.
  - After writing w[Nw-1], go to DONE.
- DONE:
  - o_done = 1 for that cycle; o_keys_valid set; hold in DONE until the next i_start.
- Latency: i_start sampled at edge 0 → o_done high after edge Nw-Nk+2.
  - 42 edges for AES-128, 48 for AES-192, 54 for AES-256.
- Round-key slots above Nr are written with zeros on each accepted start.
- o_round_key_vector is driven directly from storage (registered).
  - Contents are undefined-stable while o_busy; consumers sample only when o_keys_valid.
- i_start while o_busy is ignored: no restart, no error.
- i_reset mid-expansion returns to IDLE next edge, clears storage and all flags.
- i_start in the DONE cycle is accepted; o_done still pulses that cycle.

Optional Feature:
KEY_SCHED_ZEROIZE_EN.
- Defined: adds input i_zeroize (1 bit).
  - When high in any state, the next edge clears storage, o_keys_valid and rcon, and enters IDLE.
  - Takes priority over i_start.
- Undefined: no such port; storage is cleared only by i_reset.

Decomposition:
- Package aes_key_sched_pkg holds:
  - mode encodings;
  - functions returning Nk, Nw and Nr from mode;
  - the xtime function;
  - the FSM state encoding.
- One sub-module, key_sched_word_unit (combinational), computes t and the new word from w[i-1], w[i-Nk], i mod Nk and rcon.
  - It instantiates subbytes_block with N_BYTES = 4 and CREATE_OUTPUT_REG = 0.
  - The RotWord select is a mux ahead of the S-box.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c → w4 = a0fafe17; w43 = b6630ca6; o_done 42 edges after start; slots 11..14 all zero.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → w6 = fe0c91f7; w51 = 01002202; o_done after 48 edges.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → w8 = 9ba35411; w59 = 706c631e; o_done after 54 edges.
- Re-issue i_start during EXPAND with a different key → ignored; result equals the first key's expansion.
- i_key_size = 3 with i_start → single o_cfg_err pulse; o_busy stays 0.
- Reset mid-expansion, and i_zeroize (when the macro is defined) after DONE → all outputs 0 next cycle; a fresh start then produces the correct keys.
